// File: rtl/reg_pkg.sv
// Shared integer register-file definitions: register count, address type and ABI register indices.
package reg_pkg;

  localparam int NUM_OF_REGS      = 32;
  localparam int REG_ENCODE_WIDTH = $clog2(NUM_OF_REGS);

  typedef logic [REG_ENCODE_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);

  // RISC-V integer ABI names
  localparam reg_addr_t RA  = reg_addr_t'(1);
  localparam reg_addr_t SP  = reg_addr_t'(2);
  localparam reg_addr_t GP  = reg_addr_t'(3);
  localparam reg_addr_t TP  = reg_addr_t'(4);
  localparam reg_addr_t T0  = reg_addr_t'(5);
  localparam reg_addr_t T1  = reg_addr_t'(6);
  localparam reg_addr_t T2  = reg_addr_t'(7);
  localparam reg_addr_t S0  = reg_addr_t'(8);
  localparam reg_addr_t S1  = reg_addr_t'(9);
  localparam reg_addr_t A0  = reg_addr_t'(10);
  localparam reg_addr_t A1  = reg_addr_t'(11);
  localparam reg_addr_t A2  = reg_addr_t'(12);
  localparam reg_addr_t A3  = reg_addr_t'(13);
  localparam reg_addr_t A4  = reg_addr_t'(14);
  localparam reg_addr_t A5  = reg_addr_t'(15);
  localparam reg_addr_t A6  = reg_addr_t'(16);
  localparam reg_addr_t A7  = reg_addr_t'(17);
  localparam reg_addr_t S2  = reg_addr_t'(18);
  localparam reg_addr_t S3  = reg_addr_t'(19);
  localparam reg_addr_t S4  = reg_addr_t'(20);
  localparam reg_addr_t S5  = reg_addr_t'(21);
  localparam reg_addr_t S6  = reg_addr_t'(22);
  localparam reg_addr_t S7  = reg_addr_t'(23);
  localparam reg_addr_t S8  = reg_addr_t'(24);
  localparam reg_addr_t S9  = reg_addr_t'(25);
  localparam reg_addr_t S10 = reg_addr_t'(26);
  localparam reg_addr_t S11 = reg_addr_t'(27);
  localparam reg_addr_t T3  = reg_addr_t'(28);
  localparam reg_addr_t T4  = reg_addr_t'(29);
  localparam reg_addr_t T5  = reg_addr_t'(30);
  localparam reg_addr_t T6  = reg_addr_t'(31);

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter that holds at zero and at all-ones; simultaneous inc and dec cancel.
module sat_updown_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side scoreboard: per-register pending-write counters gate issue on RAW hazards
// and on destination-counter room; also reports underflowing writebacks and stall cycles.
module reg_scoreboard #(
  parameter int NUM_OF_REGS      = reg_pkg::NUM_OF_REGS,
  parameter int REG_ENCODE_WIDTH = $clog2(NUM_OF_REGS),
  parameter int PEND_CNT_WIDTH   = 2,
  parameter int STALL_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [REG_ENCODE_WIDTH-1:0] issue_rs1_addr,
  input  logic                        issue_rs1_used,
  input  logic [REG_ENCODE_WIDTH-1:0] issue_rs2_addr,
  input  logic                        issue_rs2_used,
  input  logic [REG_ENCODE_WIDTH-1:0] issue_rd_addr,
  input  logic                        issue_rd_wr,
  input  logic                        wb_valid,
  input  logic [REG_ENCODE_WIDTH-1:0] wb_addr,
  input  logic                        flush,
  output logic [NUM_OF_REGS-1:0]      busy_vec,
  output logic                        wb_underflow,
  output logic [STALL_CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [REG_ENCODE_WIDTH-1:0] ZERO_ADDR = REG_ENCODE_WIDTH'(reg_pkg::REG_ZERO);
  localparam logic [PEND_CNT_WIDTH-1:0]   PEND_MAX  = '1;

  logic [PEND_CNT_WIDTH-1:0] pending [NUM_OF_REGS];

  logic rs1_hazard;
  logic rs2_hazard;
  logic rd_full;
  logic fire;
  logic wb_empty;

  function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(input logic [STALL_CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign rs1_hazard = issue_rs1_used && (issue_rs1_addr != ZERO_ADDR) && (pending[issue_rs1_addr] != '0);
  assign rs2_hazard = issue_rs2_used && (issue_rs2_addr != ZERO_ADDR) && (pending[issue_rs2_addr] != '0);
  assign rd_full    = issue_rd_wr && (issue_rd_addr != ZERO_ADDR) && (pending[issue_rd_addr] == PEND_MAX);

  // Readiness reflects only registered counters: a writeback this cycle frees issue next cycle.
  assign issue_ready = !flush && !rs1_hazard && !rs2_hazard && !rd_full;
  assign fire        = issue_valid && issue_ready;
  assign wb_empty    = wb_valid && (wb_addr != ZERO_ADDR) && (pending[wb_addr] == '0);

  for (genvar r = 0; r < NUM_OF_REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign pending[r] = '0;
    end else begin : g_cnt
      logic inc;
      logic dec;

      assign inc = fire && issue_rd_wr && (issue_rd_addr == REG_ENCODE_WIDTH'(r));
      assign dec = wb_valid && (wb_addr == REG_ENCODE_WIDTH'(r)) && (pending[r] != '0);

      sat_updown_counter #(
        .WIDTH (PEND_CNT_WIDTH)
      ) u_pend_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (inc),
        .dec   (dec),
        .count (pending[r])
      );
    end
    assign busy_vec[r] = (pending[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_underflow <= 1'b0;
      stall_cnt    <= '0;
    end else begin
      if (wb_empty && !flush) begin
        wb_underflow <= 1'b1;
      end
      if (issue_valid && !issue_ready && !flush) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1_addr;
  logic        issue_rs1_used;
  logic [4:0]  issue_rs2_addr;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd_addr;
  logic        issue_rd_wr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic [31:0] busy_vec;
  logic        wb_underflow;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  reg_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1_addr (issue_rs1_addr),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_addr (issue_rs2_addr),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd_addr  (issue_rd_addr),
    .issue_rd_wr    (issue_rd_wr),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .flush          (flush),
    .busy_vec       (busy_vec),
    .wb_underflow   (wb_underflow),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_rs1_addr = '0;
    issue_rs1_used = 1'b0;
    issue_rs2_addr = '0;
    issue_rs2_used = 1'b0;
    issue_rd_addr  = '0;
    issue_rd_wr    = 1'b0;
    wb_valid       = 1'b0;
    wb_addr        = '0;
    flush          = 1'b0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    issue_valid   = 1'b1;
    issue_rd_addr = rd;
    issue_rd_wr   = 1'b1;
  endtask

  task automatic wb(input logic [4:0] a);
    idle();
    wb_valid = 1'b1;
    wb_addr  = a;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_uflow", 32'(wb_underflow), 32'h0);
    issue_rs1_addr = 5'd3;  issue_rs1_used = 1'b1;
    issue_rs2_addr = 5'd17; issue_rs2_used = 1'b1;
    issue_rd_addr  = 5'd9;  issue_rd_wr    = 1'b1;
    #1;
    chk("rst_ready", 32'(issue_ready), 32'h1);
    idle();

    // RAW hazard on x5
    issue_wr(5'd5);
    #1;
    chk("rd5_ready", 32'(issue_ready), 32'h1);
    tick();
    chk("rd5_busy", busy_vec, 32'h0000_0020);
    idle();
    issue_valid = 1'b1; issue_rs1_addr = 5'd5; issue_rs1_used = 1'b1;
    #1;
    chk("raw5_stall", 32'(issue_ready), 32'h0);
    tick(); tick(); tick();
    chk("raw5_stallcnt", 32'(stall_cnt), 32'd3);
    wb_valid = 1'b1; wb_addr = 5'd5;
    #1;
    chk("raw5_nobypass", 32'(issue_ready), 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw5_release", 32'(issue_ready), 32'h1);
    chk("raw5_busy_clr", busy_vec, 32'h0);
    chk("raw5_stallcnt2", 32'(stall_cnt), 32'd4);
    idle();

    // Register 0 never tracked
    issue_wr(5'd0);
    tick();
    chk("x0_busy", busy_vec, 32'h0);
    idle();
    issue_valid = 1'b1;
    issue_rs1_used = 1'b1; issue_rs2_used = 1'b1;
    #1;
    chk("x0_src_ready", 32'(issue_ready), 32'h1);
    wb(5'd0);
    chk("x0_wb_uflow", 32'(wb_underflow), 32'h0);

    // WAW up to MAX=3 on x7
    issue_wr(5'd7);
    tick(); tick(); tick();
    chk("rd7_busy", busy_vec, 32'h0000_0080);
    chk("rd7_full", 32'(issue_ready), 32'h0);
    wb(5'd7);
    issue_wr(5'd7);
    #1;
    chk("rd7_room", 32'(issue_ready), 32'h1);
    tick();
    chk("rd7_full2", 32'(issue_ready), 32'h0);
    wb(5'd7);
    issue_wr(5'd7);
    wb_valid = 1'b1; wb_addr = 5'd7;
    #1;
    chk("rd7_sim_ready", 32'(issue_ready), 32'h1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("rd7_sim_unchanged", 32'(issue_ready), 32'h1);
    tick();
    chk("rd7_sim_full", 32'(issue_ready), 32'h0);
    idle();
    wb(5'd7); wb(5'd7); wb(5'd7);
    chk("rd7_drained", busy_vec, 32'h0);
    chk("rd7_uflow", 32'(wb_underflow), 32'h0);

    // Flush with concurrent issue and writeback
    issue_wr(5'd3);  tick();
    issue_wr(5'd9);  tick();
    issue_wr(5'd12); tick();
    idle();
    #1;
    chk("flush_pre_busy", busy_vec, 32'h0000_1208);
    issue_wr(5'd4);
    flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd3;
    #1;
    chk("flush_ready", 32'(issue_ready), 32'h0);
    tick();
    idle();
    #1;
    chk("flush_busy", busy_vec, 32'h0);
    chk("flush_stallcnt", 32'(stall_cnt), 32'd4);
    chk("flush_uflow", 32'(wb_underflow), 32'h0);
    issue_valid = 1'b1; issue_rs1_addr = 5'd4; issue_rs1_used = 1'b1;
    #1;
    chk("flush_rd4_clear", 32'(issue_ready), 32'h1);
    idle();

    // Underflow is sticky
    wb(5'd10);
    chk("uflow_set", 32'(wb_underflow), 32'h1);
    tick(); tick(); tick();
    chk("uflow_sticky", 32'(wb_underflow), 32'h1);
    chk("uflow_cnt_zero", busy_vec, 32'h0);

    // Stall counter saturation
    issue_wr(5'd6);
    tick();
    idle();
    issue_valid = 1'b1; issue_rs2_addr = 5'd6; issue_rs2_used = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    chk("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
    chk("stall_sat_uflow", 32'(wb_underflow), 32'h1);

    // Mid-operation reset discards everything
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("rst2_busy", busy_vec, 32'h0);
    chk("rst2_stall", 32'(stall_cnt), 32'h0);
    chk("rst2_uflow", 32'(wb_underflow), 32'h0);
    issue_valid = 1'b1; issue_rs2_addr = 5'd6; issue_rs2_used = 1'b1;
    #1;
    chk("rst2_ready", 32'(issue_ready), 32'h1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
